// File: rtl/bram_tdp_be.sv
// -----------------------------------------------------------------------------
// bram_tdp_be
//
// True dual-port synchronous block RAM with per-byte write enables on both
// ports, selectable same-port read-during-write behaviour, an optional output
// register stage and a hardware clear sweep after reset.
//
// Parameters:
//   DATA           word width in bits (multiple of 8)
//   ADDR           address width, depth = 2**ADDR words
//   OUTREG         1 = extra output register stage (read latency 2)
//   RDW_MODE       same-port read-during-write: 0 = old data, 1 = merged new data
//   CLEAR_ON_RESET 1 = zero every word after reset before accepting requests
//
// Ports (x = a or b):
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   ready      high while the ports accept requests
//   collision  one-cycle pulse: both ports wrote overlapping lanes of one word
//   x_en       access enable (every enabled access also reads)
//   x_we       byte-lane write enables, bit i -> x_write[8i+7:8i]
//   x_addr     word address
//   x_write    write data
//   x_read     read data, holds its last value between reads
//   x_valid    one-cycle pulse accompanying each new x_read value
// -----------------------------------------------------------------------------
module bram_tdp_be #(
    parameter int DATA           = 32,
    parameter int ADDR           = 10,
    parameter int OUTREG         = 0,
    parameter int RDW_MODE       = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  ready,
    output logic                  collision,

    input  logic                  a_en,
    input  logic [DATA/8-1:0]     a_we,
    input  logic [ADDR-1:0]       a_addr,
    input  logic [DATA-1:0]       a_write,
    output logic [DATA-1:0]       a_read,
    output logic                  a_valid,

    input  logic                  b_en,
    input  logic [DATA/8-1:0]     b_we,
    input  logic [ADDR-1:0]       b_addr,
    input  logic [DATA-1:0]       b_write,
    output logic [DATA-1:0]       b_read,
    output logic                  b_valid
);

    localparam int BYTES = DATA / 8;
    localparam int DEPTH = 2 ** ADDR;

    typedef enum logic {
        ST_CLEAR,
        ST_RUN
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR-1:0]   clr_cnt_q, clr_cnt_d;
    logic              clr_we;

    logic              run;
    logic              a_acc, b_acc;
    logic [BYTES-1:0]  a_wl, b_wl;
    logic [DATA-1:0]   a_rd_d, b_rd_d;
    logic              coll_d, coll_q;

    logic [DATA-1:0]   a_read_q, b_read_q;
    logic              a_valid_q, b_valid_q;

    logic [DATA-1:0]   mem [DEPTH];

    // -------------------------------------------------------------------------
    // Clear / run control
    // -------------------------------------------------------------------------
    // NOTE: every signal written here gets a default first, so no path through
    // the block leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        clr_we    = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                if (CLEAR_ON_RESET != 0) begin
                    clr_we    = 1'b1;
                    clr_cnt_d = clr_cnt_q + 1'b1;
                    if (clr_cnt_q == '1) begin
                        state_d = ST_RUN;
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    assign run   = (state_q == ST_RUN);
    assign ready = run;

    // Requests are only honoured once the clear sweep has finished.
    assign a_acc = run & a_en;
    assign b_acc = run & b_en;
    assign a_wl  = a_we & {BYTES{a_acc}};
    assign b_wl  = b_we & {BYTES{b_acc}};

    // -------------------------------------------------------------------------
    // Storage
    // -------------------------------------------------------------------------
    // NOTE: the array has no reset; block RAM cannot be reset in one cycle, so
    // zeroing is done by the clear sweep one word per cycle instead.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_cnt_q] <= '0;
        end else begin
            for (int i = 0; i < BYTES; i++) begin
                // Port A is assigned last so it wins on overlapping lanes of a
                // same-address write; other lanes keep their own port's data.
                if (b_wl[i]) mem[b_addr][8*i +: 8] <= b_write[8*i +: 8];
                if (a_wl[i]) mem[a_addr][8*i +: 8] <= a_write[8*i +: 8];
            end
        end
    end

    // Read path: the array is sampled before this edge's writes land, which
    // gives old data across ports. Write-through only overlays the lanes the
    // same port is writing.
    always_comb begin
        a_rd_d = mem[a_addr];
        b_rd_d = mem[b_addr];
        if (RDW_MODE != 0) begin
            for (int i = 0; i < BYTES; i++) begin
                if (a_wl[i]) a_rd_d[8*i +: 8] = a_write[8*i +: 8];
                if (b_wl[i]) b_rd_d[8*i +: 8] = b_write[8*i +: 8];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Collision flag
    // -------------------------------------------------------------------------
    assign coll_d = a_acc & b_acc & (a_addr == b_addr) & (|(a_we & b_we));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            coll_q <= 1'b0;
        end else begin
            coll_q <= coll_d;
        end
    end

    assign collision = coll_q;

    // -------------------------------------------------------------------------
    // Read output pipeline
    // -------------------------------------------------------------------------
    if (OUTREG != 0) begin : g_outreg
        logic [DATA-1:0] a_s1_q, b_s1_q;
        logic            a_s1v_q, b_s1v_q;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                a_s1_q    <= '0;
                b_s1_q    <= '0;
                a_s1v_q   <= 1'b0;
                b_s1v_q   <= 1'b0;
                a_read_q  <= '0;
                b_read_q  <= '0;
                a_valid_q <= 1'b0;
                b_valid_q <= 1'b0;
            end else begin
                a_s1v_q   <= a_acc;
                b_s1v_q   <= b_acc;
                if (a_acc) a_s1_q <= a_rd_d;
                if (b_acc) b_s1_q <= b_rd_d;
                a_valid_q <= a_s1v_q;
                b_valid_q <= b_s1v_q;
                if (a_s1v_q) a_read_q <= a_s1_q;
                if (b_s1v_q) b_read_q <= b_s1_q;
            end
        end
    end else begin : g_direct
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                a_read_q  <= '0;
                b_read_q  <= '0;
                a_valid_q <= 1'b0;
                b_valid_q <= 1'b0;
            end else begin
                a_valid_q <= a_acc;
                b_valid_q <= b_acc;
                if (a_acc) a_read_q <= a_rd_d;
                if (b_acc) b_read_q <= b_rd_d;
            end
        end
    end

    assign a_read  = a_read_q;
    assign b_read  = b_read_q;
    assign a_valid = a_valid_q;
    assign b_valid = b_valid_q;

endmodule

// File: doc/bram_tdp_be.md
# bram_tdp_be

True dual-port synchronous block RAM with per-byte write enables on both ports, selectable read-during-write behaviour, an optional output register stage and hardware memory clear after reset. It is the next generation of the SoC's two-port sync RAM primitive: both ports may write, each read returns a valid strobe, and simultaneous same-address writes are arbitrated and flagged. It is used for CPU/DMA shared buffers and writable tables on the ECP5 targets.

## Interface
Parameters:
- DATA, 32, word width in bits; must be a multiple of 8
- ADDR, 10, address width; depth = 2**ADDR words
- OUTREG, 0, 1 = add an output register stage (read latency 2)
- RDW_MODE, 0, same-port read-during-write: 0 = read-first (old data), 1 = write-through (new data)
- CLEAR_ON_RESET, 1, 1 = zero all words after reset; 0 = skip clear, ready immediately

Ports (BYTES = DATA/8):
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- ready  out  1  high when ports accept requests
- collision  out  1  one-cycle pulse: same-address write conflict detected
- a_en  in  1  port A access enable
- a_we  in  BYTES  port A byte write enables (bit i -> a_write[8i+7:8i])
- a_addr  in  ADDR  port A word address
- a_write  in  DATA  port A write data
- a_read  out  DATA  port A read data
- a_valid  out  1  port A read data valid pulse
- b_en, b_we, b_addr, b_write, b_read, b_valid: port B, same widths and meanings

## Operation
- States: CLEAR, RUN. Reset asserted -> CLEAR, clear counter = 0, all outputs 0.
- CLEAR (CLEAR_ON_RESET=1): each cycle writes 0 to word[counter], counter += 1; after word 2**ADDR-1 -> RUN. ready=0; a_en/b_en ignored, no valid pulses. CLEAR_ON_RESET=0: reset release goes straight to RUN.
- RUN: ready=1. Access when x_en=1: lanes with x_we[i]=1 written; a read is performed on every enabled access (with or without writes), x_valid pulses with its data.
- Same-port read-during-write: RDW_MODE=0 returns pre-write word; RDW_MODE=1 returns word after byte-merge (unwritten lanes old).
- Cross-port: read on one port of an address written by the other port in the same cycle always returns the old word.
- Both ports enabled, same address, overlapping write lanes (a_we & b_we != 0): port A wins on overlapping lanes, non-overlapping lanes take their own port's data; collision pulses. Same address with disjoint lanes, or reads only: no collision.
- x_read holds its last value while no new read completes; reset clears to 0.
- Reset mid-CLEAR or mid-RUN: pipeline flushed (valid=0, read regs 0), counter restarts at 0; memory contents otherwise undefined until clear completes.

## Timing
- ready rises in the cycle after the last clear write; clear takes exactly 2**ADDR cycles after reset release.
- Read latency: OUTREG=0 -> data/valid registered 1 cycle after the enabled edge; OUTREG=1 -> 2 cycles. Fully pipelined, one access per port per cycle.
- collision registered, asserted 1 cycle after the conflicting edge, for 1 cycle per conflict.
- Write takes effect at the enabling edge; a read of that address on the next cycle on either port sees new data.
- Address wrap: counter and addresses are ADDR bits, no out-of-range case.

## Test plan
- Reset, ADDR=4: ready=0 for 16 cycles, then 1; read all 16 words on A -> all 0x00000000, a_valid one pulse per read, latency 1.
- A writes 0xDEADBEEF to addr 3, we=4'b1111; next cycle B reads 3 -> b_read=0xDEADBEEF 1 cycle later.
- Byte lanes: addr 5 = 0x11223344, A writes 0xAABBCCDD we=4'b0101 -> read gives 0x11BB33DD.
- RDW: addr 7 = 0x1, A writes 0x2 and reads 7 same cycle -> a_read=0x1 (RDW_MODE=0) / 0x2 (RDW_MODE=1); B reading 7 same cycle -> 0x1 both modes.
- Collision: A writes 0xAAAAAAAA we=1100, B writes 0xBBBBBBBB we=0110 to addr 9 -> word = 0xAAAABBxx-lane merge 0xAAAABB<old byte0>, collision pulse 1 cycle; disjoint lanes -> no pulse.
- OUTREG=1: latency 2 with back-to-back reads on addresses 0,1,2; reset asserted mid-clear at counter=8 -> ready stays 0 until 16 more cycles after release.
